// File: rtl/spi_fpga_pkg.sv
// Shared constants, state encoding and width helpers for the SPI master arbiter.
package spi_fpga_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_TRANSFER,
    ST_COMPLETE,
    ST_GAP
  } state_t;

  localparam int DEF_REQUESTERS     = 4;
  localparam int DEF_PACK_LENGTH    = 8;
  localparam int DEF_GAP_CLOCKS     = 4;
  localparam int DEF_LAUNCH_TIMEOUT = 64;

  // Pointer/index width covers the largest supported requester count.
  localparam int MAX_REQUESTERS = 8;
  localparam int IDX_W          = $clog2(MAX_REQUESTERS);

  // One counter serves both the launch timeout and the inter-frame gap.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction
endpackage

// File: rtl/spi_fpga_rr_picker.sv
// Combinational round-robin search: first set request after i_ptr, wrapping.
module spi_fpga_rr_picker
  import spi_fpga_pkg::*;
#(
  parameter int N = DEF_REQUESTERS
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);
  always_comb begin : pick
    int p;
    p       = 0;
    o_grant = '0;
    o_idx   = '0;
    // Walk from lowest priority up so the nearest request after i_ptr wins last.
    for (int k = N; k >= 1; k--) begin
      p = int'(i_ptr) + k;
      if (p >= N) p = p - N;
      for (int i = 0; i < N; i++) begin
        if (i_req[i] && (i == p)) begin
          o_grant    = '0;
          o_grant[i] = 1'b1;
          o_idx      = IDX_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/spi_fpga_arbiter.sv
// Shares one SPI master among several requesters with round-robin arbitration.
module spi_fpga_arbiter
  import spi_fpga_pkg::*;
#(
  parameter int REQUESTERS     = DEF_REQUESTERS,
  parameter int PACK_LENGTH    = DEF_PACK_LENGTH,
  parameter int GAP_CLOCKS     = DEF_GAP_CLOCKS,
  parameter int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
  input  logic                              IN_CLOCK,
  input  logic                              IN_RESET,
  input  logic [REQUESTERS-1:0]             IN_REQUEST,
  input  logic [REQUESTERS*PACK_LENGTH-1:0] IN_REQUEST_DATA,
  output logic [REQUESTERS-1:0]             OUT_GRANT,
  output logic [REQUESTERS-1:0]             OUT_DONE,
  output logic                              OUT_ERROR,
  output logic [PACK_LENGTH-1:0]            OUT_RECEIVE_DATA,
  output logic                              OUT_LAUNCH,
  output logic [PACK_LENGTH-1:0]            OUT_MASTER_DATA,
  input  logic                              IN_MASTER_CS,
  input  logic [PACK_LENGTH-1:0]            IN_MASTER_RECEIVE_DATA,
  input  logic                              IN_MASTER_ACTION_DONE,
  output logic [REQUESTERS-1:0]             OUT_CS,
  output logic                              OUT_BUSY
);
  localparam int               CNT_W    = cnt_width(GAP_CLOCKS, LAUNCH_TIMEOUT);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(REQUESTERS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLOCKS - 1);

  state_t                  r_state, w_next;
  logic [REQUESTERS-1:0]   r_grant, r_done, w_pick_grant;
  logic [IDX_W-1:0]        r_ptr, w_pick_idx;
  logic [PACK_LENGTH-1:0]  r_mdata, r_rx, w_word;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err, r_act_d, w_act_rise, w_timeout;

  spi_fpga_rr_picker #(.N(REQUESTERS)) u_picker (
    .i_req   (IN_REQUEST),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_word = '0;
    for (int i = 0; i < REQUESTERS; i++)
      if (w_pick_grant[i]) w_word = IN_REQUEST_DATA[i*PACK_LENGTH +: PACK_LENGTH];
  end

  assign w_act_rise = IN_MASTER_ACTION_DONE & ~r_act_d;
  assign w_timeout  = (r_state == ST_LAUNCH) && IN_MASTER_CS && (r_cnt == TMO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (|IN_REQUEST) w_next = ST_LAUNCH;
      ST_LAUNCH:   if (!IN_MASTER_CS) w_next = ST_TRANSFER;
                   else if (w_timeout) w_next = ST_GAP;
      ST_TRANSFER: if (w_act_rise) w_next = ST_COMPLETE;
      ST_COMPLETE: w_next = ST_GAP;
      ST_GAP:      if (r_cnt == GAP_LAST) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
    if (IN_RESET) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
    if (IN_RESET) begin
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_ptr   <= PTR_RST;
      r_mdata <= '0;
      r_rx    <= '0;
      r_cnt   <= '0;
      r_act_d <= 1'b0;
    end else begin
      r_act_d <= IN_MASTER_ACTION_DONE;
      r_done  <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: if (|IN_REQUEST) begin
          r_grant <= w_pick_grant;
          r_ptr   <= w_pick_idx;
          r_mdata <= w_word;
          r_cnt   <= '0;
        end
        ST_LAUNCH: if (IN_MASTER_CS) begin
          // Master never answered: report the abort to the owner and release it.
          if (w_timeout) begin
            r_done  <= r_grant;
            r_err   <= 1'b1;
            r_grant <= '0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_TRANSFER: if (w_act_rise) begin
          r_rx   <= IN_MASTER_RECEIVE_DATA;
          r_done <= r_grant;
        end
        ST_COMPLETE: begin
          r_grant <= '0;
          r_cnt   <= '0;
        end
        ST_GAP:  r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign OUT_GRANT        = r_grant;
  assign OUT_DONE         = r_done;
  assign OUT_ERROR        = r_err;
  assign OUT_RECEIVE_DATA = r_rx;
  assign OUT_MASTER_DATA  = r_mdata;
  assign OUT_LAUNCH       = (r_state == ST_LAUNCH);
  assign OUT_BUSY         = (r_state != ST_IDLE);
  assign OUT_CS           = ~r_grant | {REQUESTERS{IN_MASTER_CS}};
endmodule

// File: doc/spi_fpga_arbiter.md
SPI_FPGA_ARBITER -- requirements
Module: spi_fpga_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 4: number of requesters sharing one SPI_FPGA_MASTER, range 2..8.
REQ-002 Parameter PACK_LENGTH, default 8: SPI word width; shall equal the attached master's PACK_LENGTH.
REQ-003 Parameter GAP_CLOCKS, default 4: idle IN_CLOCK cycles enforced between consecutive transactions, range 1..255.
REQ-004 Parameter LAUNCH_TIMEOUT, default 64: cycles allowed for IN_MASTER_CS to fall after launch.
REQ-005 IN_CLOCK  input  1  system clock; one clock domain; all logic on rising edge.
REQ-006 IN_RESET  input  1  asynchronous, active-high reset.
REQ-007 IN_REQUEST  input  REQUESTERS  level request per requester; held until its OUT_DONE pulse.
REQ-008 IN_REQUEST_DATA  input  REQUESTERS*PACK_LENGTH  transmit word; requester i occupies bits [i*PACK_LENGTH +: PACK_LENGTH].
REQ-009 OUT_GRANT  output  REQUESTERS  one-hot; marks the requester owning the current transaction.
REQ-010 OUT_DONE  output  REQUESTERS  one-cycle pulse to the owner on completion or abort.
REQ-011 OUT_ERROR  output  1  one-cycle pulse, coincident with OUT_DONE, on launch timeout.
REQ-012 OUT_RECEIVE_DATA  output  PACK_LENGTH  word received for the owner; valid while OUT_DONE is high, held until the next capture.
REQ-013 OUT_LAUNCH  output  1  drives master IN_LAUNCH.
REQ-014 OUT_MASTER_DATA  output  PACK_LENGTH  drives master IN_MASTER_DATA.
REQ-015 IN_MASTER_CS  input  1  master CS, active-low.
REQ-016 IN_MASTER_RECEIVE_DATA  input  PACK_LENGTH  master OUT_MASTER_RECEIVE_DATA.
REQ-017 IN_MASTER_ACTION_DONE  input  1  master OUT_MASTER_ACTION_DONE.
REQ-018 OUT_CS  output  REQUESTERS  per-slave active-low chip selects; OUT_CS[i] = IN_MASTER_CS when OUT_GRANT[i], else 1 (combinational).
REQ-019 OUT_BUSY  output  1  high in every state except IDLE.

Function
REQ-020 The FSM shall have the states IDLE, LAUNCH, TRANSFER, COMPLETE and GAP.
REQ-021 IDLE: if any IN_REQUEST bit is set, the FSM shall select a winner round-robin, starting the search at (last winner + 1) mod REQUESTERS, and go to LAUNCH.
REQ-022 Round-robin pointer reset value shall be REQUESTERS-1, so requester 0 wins first after reset.
REQ-023 On entry to LAUNCH, the block shall register OUT_GRANT and OUT_MASTER_DATA from the winner's word; both shall stay stable until the FSM leaves COMPLETE.
REQ-024 LAUNCH: OUT_LAUNCH=1; on IN_MASTER_CS sampled low -> OUT_LAUNCH=0 and go to TRANSFER.
REQ-025 LAUNCH: if LAUNCH_TIMEOUT cycles pass without CS low -> OUT_LAUNCH=0, pulse OUT_ERROR and owner's OUT_DONE, go to GAP.
REQ-026 TRANSFER: on the first IN_MASTER_ACTION_DONE rising edge (registered edge detect), the block shall capture IN_MASTER_RECEIVE_DATA into OUT_RECEIVE_DATA and go to COMPLETE.
REQ-027 COMPLETE: the block shall pulse the owner's OUT_DONE for exactly 1 cycle, clear OUT_GRANT and go to GAP; request-to-DONE latency is frame time + 3 cycles minimum.
REQ-028 GAP: the block shall count GAP_CLOCKS cycles, then go to IDLE; requests arriving during GAP shall not be lost.
REQ-029 A requester dropping IN_REQUEST mid-transaction shall not abort the transaction; it shall complete normally and OUT_DONE shall still pulse.
REQ-030 Simultaneous requests shall be arbitrated in round-robin order only; the search shall be combinational over REQUESTERS bits.
REQ-031 An IN_MASTER_ACTION_DONE edge outside TRANSFER shall be ignored.

Reset
REQ-032 IN_RESET high shall force: state IDLE, OUT_GRANT=0, OUT_DONE=0, OUT_ERROR=0, OUT_LAUNCH=0, OUT_MASTER_DATA=0, OUT_RECEIVE_DATA=0, counters=0, pointer=REQUESTERS-1, so that OUT_CS is all ones.
REQ-033 Reset mid-transfer shall drop OUT_LAUNCH and grants immediately; no OUT_DONE shall pulse for the aborted transaction.

Structure
REQ-034 A shared package spi_fpga_pkg shall hold the state encodings, the $clog2-derived index/counter widths and the default parameter constants.
REQ-035 Round-robin selection shall live in one sub-module, spi_fpga_rr_picker, with inputs request vector and pointer and outputs one-hot grant and index; the FSM and master interface shall live in the top.

Verification
REQ-036 Single request: requester 0 sends 8'b11101010 and the slave returns 8'b01010011 -> OUT_DONE[0] pulses once, OUT_RECEIVE_DATA=8'h53, OUT_CS[0] is low during the frame and OUT_CS[3:1] stays high.
REQ-037 All four request at once -> grant order 0,1,2,3; each OUT_DONE fires once; spacing between frames >= GAP_CLOCKS cycles.
REQ-038 Requester 2 holds its request continuously while requester 1 requests -> grants alternate 1,2,1,2 with no starvation.
REQ-039 Master CS tied high -> OUT_ERROR and OUT_DONE pulse after 64 cycles; the FSM returns to IDLE after the gap.
REQ-040 IN_RESET asserted at mid-frame (bit 4 of 8) -> all outputs take their reset values asynchronously, no OUT_DONE fires, and the next request is granted to requester 0.
REQ-041 Requester drops IN_REQUEST during TRANSFER -> the frame completes, OUT_DONE pulses, and no second transaction is started for it.
